// File: rtl/uart_tx_periph.sv
// uart_tx_periph: memory-mapped UART transmitter with a small TX FIFO.
// Register map (byte offsets from BASE_ADDR):
//   0x0 TXD    W: queue wdata[7:0]             R: 0
//   0x4 STATUS R: {count, ovf, irq_pend, empty, full, busy}
//              W: bit3 clears irq_pend, bit4 clears ovf
//   0x8 CTRL   R/W: bit0 ie, bit1 odd parity (parity builds only)
// Frames are 8N1, LSB first, each bit BAUD_DIV clocks long.
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit between
// the data bits and the stop bit (even parity, odd when CTRL[1]=1).

module uart_tx_periph #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0020,
  parameter int unsigned BAUD_DIV  = 10417,
  parameter int unsigned FIFO_AW   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        irq
);

  localparam int unsigned        DEPTH     = 1 << FIFO_AW;
  localparam int unsigned        CNT_W     = FIFO_AW + 1;
  localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [15:0]        BAUD_LOAD = 16'(BAUD_DIV - 1);
  localparam logic [29:0]        TXD_WA    = BASE_ADDR[31:2];
  localparam logic [29:0]        STAT_WA   = TXD_WA + 30'd1;
  localparam logic [29:0]        CTRL_WA   = TXD_WA + 30'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  // Bus decode
  logic hit_txd, hit_stat, hit_ctrl;
  logic push, push_ok, pop, full, empty;

  // FIFO
  logic [7:0]         fifo_mem [DEPTH];
  logic [7:0]         fifo_rd;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [2:0]         count_rd;

  // Serialiser
  state_e      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        load_frame, irq_set;

  // Control / status
  logic ie_q, ie_d, ovf_q, ovf_d, irq_pend_q, irq_pend_d, irq_q, irq_d;
`ifdef UART_TX_PARITY_EN
  logic odd_q, odd_d, par_q, par_d;
`endif

  logic unused_bits;

  assign hit_txd  = (addr[31:2] == TXD_WA);
  assign hit_stat = (addr[31:2] == STAT_WA);
  assign hit_ctrl = (addr[31:2] == CTRL_WA);

  assign full     = (count_q == CNT_FULL);
  assign empty    = (count_q == '0);
  assign push     = MemWr & hit_txd;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still fits.
  assign push_ok  = push & (~full | pop);
  assign fifo_rd  = fifo_mem[rd_ptr_q];
  assign count_rd = 3'(count_q);

  assign irq         = irq_q;
  assign unused_bits = ^{addr[1:0], wdata[31:8]};

  // FIFO storage: written on accepted pushes only.
  // NOTE: the data array has no reset; count and pointers define which entries
  // are valid, so stale contents are never observed and the array stays plain storage.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= wdata[7:0];
  end

  // FIFO pointer and occupancy update.
  // NOTE: every always_comb output gets its default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (push_ok && !pop)      count_d = count_q + CNT_ONE;
    else if (pop && !push_ok) count_d = count_q - CNT_ONE;
  end

  // Frame FSM: next state, baud/bit counters and shift register.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    load_frame = 1'b0;
    irq_set    = 1'b0;
    pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d      = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        load_frame = ~empty;
      end
      S_START: begin
        if (baud_q == '0) begin
          state_d = S_DATA;
          baud_d  = BAUD_LOAD;
          bit_d   = '0;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      S_DATA: begin
        if (baud_q == '0) begin
          baud_d  = BAUD_LOAD;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_q == '0) begin
          state_d = S_STOP;
          baud_d  = BAUD_LOAD;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
`endif
      S_STOP: begin
        if (baud_q == '0) begin
          if (empty) begin
            state_d = S_IDLE;
            irq_set = 1'b1;
          end else begin
            load_frame = 1'b1;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Start a new frame from IDLE or straight out of STOP (no idle gap).
    if (load_frame) begin
      pop     = 1'b1;
      shift_d = fifo_rd;
      state_d = S_START;
      baud_d  = BAUD_LOAD;
      bit_d   = '0;
`ifdef UART_TX_PARITY_EN
      par_d   = odd_q ? ~^fifo_rd : ^fifo_rd;
`endif
    end
  end

  // Control and sticky status bits; a set wins over a same-cycle clear.
  always_comb begin
    ie_d       = ie_q;
    ovf_d      = ovf_q;
    irq_pend_d = irq_pend_q;
`ifdef UART_TX_PARITY_EN
    odd_d      = odd_q;
`endif
    if (MemWr && hit_ctrl) begin
      ie_d  = wdata[0];
`ifdef UART_TX_PARITY_EN
      odd_d = wdata[1];
`endif
    end
    if (MemWr && hit_stat) begin
      if (wdata[3]) irq_pend_d = 1'b0;
      if (wdata[4]) ovf_d      = 1'b0;
    end
    if (push && !push_ok) ovf_d      = 1'b1;
    if (irq_set)          irq_pend_d = 1'b1;
    irq_d = irq_pend_q & ie_q;
  end

  // Serial line driven from registered state: high whenever idle or in reset.
  always_comb begin
    tx = 1'b1;
    case (state_q)
      S_START:  tx = 1'b0;
      S_DATA:   tx = shift_q[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx = par_q;
`endif
      default:  tx = 1'b1;
    endcase
  end

  // Read mux: zero unless a mapped register is being read.
  always_comb begin
    rdata = '0;
    if (MemRd) begin
      if (hit_stat) begin
        rdata[7:0] = {count_rd, ovf_q, irq_pend_q, empty, full, (state_q != S_IDLE)};
      end else if (hit_ctrl) begin
        rdata[0] = ie_q;
`ifdef UART_TX_PARITY_EN
        rdata[1] = odd_q;
`endif
      end
    end
  end

  // State registers with asynchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      ie_q       <= 1'b0;
      ovf_q      <= 1'b0;
      irq_pend_q <= 1'b0;
      irq_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
      odd_q      <= 1'b0;
      par_q      <= 1'b0;
`endif
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      ie_q       <= ie_d;
      ovf_q      <= ovf_d;
      irq_pend_q <= irq_pend_d;
      irq_q      <= irq_d;
`ifdef UART_TX_PARITY_EN
      odd_q      <= odd_d;
      par_q      <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_periph.sv
// Testbench for uart_tx_periph (BAUD_DIV=4, FIFO_AW=2). A background monitor
// decodes frames on tx and compares them with a scoreboard of queued bytes.
`timescale 1ns/1ps
module tb_uart_tx_periph;

  localparam logic [31:0] BASE    = 32'h4000_0020;
  localparam logic [31:0] A_TXD   = BASE;
  localparam logic [31:0] A_STAT  = BASE + 32'd4;
  localparam logic [31:0] A_CTRL  = BASE + 32'd8;
  localparam logic [31:0] A_UNMAP = BASE + 32'd12;
  localparam int          BAUD    = 4;
`ifdef UART_TX_PARITY_EN
  localparam int          FRAME_BITS = 11;
  localparam logic [31:0] CTRL_MASK  = 32'h3;
`else
  localparam int          FRAME_BITS = 10;
  localparam logic [31:0] CTRL_MASK  = 32'h1;
`endif
  localparam int FRAME_CYC = FRAME_BITS * BAUD;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRd, MemWr;
  logic [31:0] addr, wdata, rdata;
  logic        tx, irq;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       par;
  } exp_t;

  exp_t sb_q[$];
  logic cur_odd     = 1'b0;
  int   rst_epoch   = 0;
  int   frames_seen = 0;
  bit   mon_busy    = 1'b0;

  uart_tx_periph #(
    .BASE_ADDR (BASE),
    .BAUD_DIV  (BAUD),
    .FIFO_AW   (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .MemRd (MemRd),
    .MemWr (MemWr),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .tx    (tx),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- bus helpers
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    MemWr = 1'b1;
    addr  = a;
    wdata = d;
    @(posedge clk);
    #1;
    MemWr = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    MemRd = 1'b1;
    addr  = a;
    #1;
    d     = rdata;
    MemRd = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    exp_t e;
    e.data = b;
    e.par  = cur_odd ? ~^b : ^b;
    sb_q.push_back(e);
    bus_write(A_TXD, {24'h0, b});
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while ((sb_q.size() != 0 || mon_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb_q.size() != 0 || mon_busy) begin
      failures++;
      $display("FAIL %s_drain: %0d frames still pending after %0d cycles, required 0", name, sb_q.size(), budget);
    end
  endtask

  // Counts busy cycles from the first low tx sample and records tx per cycle.
  task automatic measure_frame(input int budget, output int cycles, output logic [63:0] wave);
    logic [31:0] st;
    bit started = 1'b0;
    cycles = 0;
    wave   = '0;
    for (int i = 0; i < budget; i++) begin
      bus_read(A_STAT, st);
      if (!started && tx === 1'b0) started = 1'b1;
      if (started) begin
        if (st[0] !== 1'b1) break;
        if (cycles < 64) wave[cycles] = tx;
        cycles++;
      end
    end
  endtask

  // ---------------------------------------------------------------- monitor
  always begin : monitor
    logic [FRAME_BITS-1:0] got, exp_bits;
    int   ep;
    exp_t e;
    @(negedge clk);
    if (tx === 1'b0) begin
      mon_busy = 1'b1;
      ep = rst_epoch;
      repeat (BAUD / 2) @(negedge clk);
      got[0] = tx;
      for (int i = 1; i < FRAME_BITS; i++) begin
        repeat (BAUD) @(negedge clk);
        got[i] = tx;
      end
      if (ep == rst_epoch) begin
        frames_seen++;
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL frame_unexpected: got frame bits %b, required no frame", got);
        end else begin
          e = sb_q.pop_front();
`ifdef UART_TX_PARITY_EN
          exp_bits = {1'b1, e.par, e.data, 1'b0};
`else
          exp_bits = {1'b1, e.data, 1'b0};
`endif
          if (got !== exp_bits) begin
            failures++;
            $display("FAIL frame_bits: got %b, required %b (byte %h)", got, exp_bits, e.data);
          end
        end
      end
      repeat (BAUD / 2 - 1) @(negedge clk);
      mon_busy = 1'b0;
    end
  end

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    logic [31:0] d;
    checks++;
    if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx: got %b, required 1", tx); end
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq: got %b, required 0", irq); end
    MemRd = 1'b0;
    addr  = A_STAT;
    #1;
    checks++;
    if (rdata !== 32'h0) begin failures++; $display("FAIL rdata_unselected: got %h, required 0", rdata); end
    bus_read(A_STAT, d);
    checks++;
    if (d !== 32'h04) begin failures++; $display("FAIL reset_status_in_reset: got %h, required 04", d); end
    @(negedge clk);
    reset = 1'b1;
    bus_read(A_STAT, d);
    checks++;
    if (d !== 32'h04) begin failures++; $display("FAIL reset_status: got %h, required 04", d); end
    bus_read(A_CTRL, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL reset_ctrl: got %h, required 0", d); end
  endtask

  task automatic test_regs();
    logic [31:0] d;
    bus_write(A_UNMAP, 32'hFF);
    bus_read(A_UNMAP, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL unmapped_read: got %h, required 0", d); end
    bus_read(A_TXD, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL txd_read: got %h, required 0", d); end
    bus_read(A_STAT + 32'd3, d);
    checks++;
    if (d !== 32'h04) begin failures++; $display("FAIL status_byte_offset: got %h, required 04", d); end
    bus_write(A_CTRL, 32'hFFFF_FFFF);
    bus_read(A_CTRL, d);
    checks++;
    if (d !== CTRL_MASK) begin failures++; $display("FAIL ctrl_mask: got %h, required %h", d, CTRL_MASK); end
    bus_write(A_CTRL, 32'h0);
    bus_read(A_CTRL, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL ctrl_clear: got %h, required 0", d); end
  endtask

  task automatic test_single();
    int cyc;
    logic [63:0] wave, exp_wave;
    logic [FRAME_BITS-1:0] fv;
    bus_write(A_STAT, 32'h18);
    send_byte(8'h55);
    measure_frame(200, cyc, wave);
    checks++;
    if (cyc != FRAME_CYC) begin failures++; $display("FAIL single_length: got %0d cycles, required %0d", cyc, FRAME_CYC); end
`ifdef UART_TX_PARITY_EN
    fv = {1'b1, 1'b0, 8'h55, 1'b0};
`else
    fv = {1'b1, 8'h55, 1'b0};
`endif
    exp_wave = '0;
    for (int c = 0; c < FRAME_CYC; c++) exp_wave[c] = fv[c / BAUD];
    checks++;
    if (wave !== exp_wave) begin failures++; $display("FAIL single_waveform: got %h, required %h", wave, exp_wave); end
    wait_drain(100, "single");
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [63:0] wave;
    logic [31:0] d;
    bus_write(A_STAT, 32'h18);
    send_byte(8'hA5);
    send_byte(8'h3C);
    measure_frame(300, cyc, wave);
    checks++;
    if (cyc != 2 * FRAME_CYC) begin failures++; $display("FAIL b2b_length: got %0d cycles, required %0d", cyc, 2 * FRAME_CYC); end
    wait_drain(100, "b2b");
    bus_read(A_STAT, d);
    checks++;
    if (d !== 32'h0C) begin failures++; $display("FAIL b2b_status: got %h, required 0C", d); end
  endtask

  task automatic test_overflow();
    logic [7:0]  bytes [6];
    logic [31:0] d;
    int f0;
    bytes = '{8'hC1, 8'h02, 8'h93, 8'h7E, 8'h4D, 8'hEE};
    bus_write(A_STAT, 32'h18);
    f0 = frames_seen;
    for (int i = 0; i < 5; i++) send_byte(bytes[i]);
    bus_write(A_TXD, {24'h0, bytes[5]});
    bus_read(A_STAT, d);
    checks++;
    if (d !== 32'h93) begin failures++; $display("FAIL ovf_status_full: got %h, required 93", d); end
    wait_drain(5 * FRAME_CYC + 100, "ovf");
    repeat (FRAME_CYC + 20) @(negedge clk);
    checks++;
    if (frames_seen - f0 != 5) begin failures++; $display("FAIL ovf_frame_count: got %0d, required 5", frames_seen - f0); end
    bus_read(A_STAT, d);
    checks++;
    if (d !== 32'h1C) begin failures++; $display("FAIL ovf_status_done: got %h, required 1C", d); end
  endtask

  task automatic test_irq();
    logic [31:0] st;
    bit seen = 1'b0;
    bit done = 1'b0;
    bus_write(A_STAT, 32'h18);
    bus_write(A_CTRL, 32'h1);
    send_byte(8'h01);
    for (int i = 0; i < 3 * FRAME_CYC && !done; i++) begin
      bus_read(A_STAT, st);
      if (st[0] === 1'b1) seen = 1'b1;
      else if (seen) begin
        done = 1'b1;
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL irq_delay: got irq %b at stop end, required 0", irq); end
        checks++;
        if (st[3] !== 1'b1) begin failures++; $display("FAIL irq_pend_set: got %b, required 1", st[3]); end
      end
    end
    checks++;
    if (!done) begin failures++; $display("FAIL irq_frame_timeout: got no frame end, required one"); end
    bus_read(A_STAT, st);
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL irq_rise: got %b, required 1", irq); end
    bus_write(A_STAT, 32'h08);
    bus_read(A_STAT, st);
    checks++;
    if (st[3] !== 1'b0 || irq !== 1'b1) begin
      failures++;
      $display("FAIL irq_clear: got pend %b irq %b, required pend 0 irq 1", st[3], irq);
    end
    @(posedge clk);
    #1;
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL irq_fall: got %b, required 0", irq); end
    bus_write(A_CTRL, 32'h0);
    wait_drain(100, "irq");
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    int cyc;
    logic [63:0] wave;
    bus_write(A_CTRL, 32'h0);
    cur_odd = 1'b0;
    send_byte(8'h07);
    measure_frame(200, cyc, wave);
    checks++;
    if (cyc != 44) begin failures++; $display("FAIL parity_length: got %0d cycles, required 44", cyc); end
    wait_drain(100, "parity_even");
    bus_write(A_CTRL, 32'h2);
    cur_odd = 1'b1;
    send_byte(8'h07);
    wait_drain(200, "parity_odd");
    bus_write(A_CTRL, 32'h0);
    cur_odd = 1'b0;
  endtask
`endif

  task automatic test_reset_mid_frame();
    logic [31:0] d;
    int lows = 0;
    int f0;
    bus_write(A_STAT, 32'h18);
    bus_write(A_TXD, 32'hF0);
    bus_write(A_TXD, 32'h0F);
    repeat (10) @(negedge clk);
    #2;
    reset = 1'b0;
    rst_epoch++;
    #1;
    checks++;
    if (tx !== 1'b1) begin failures++; $display("FAIL midreset_tx: got %b, required 1", tx); end
    bus_read(A_STAT, d);
    checks++;
    if (d !== 32'h04) begin failures++; $display("FAIL midreset_status: got %h, required 04", d); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    f0 = frames_seen;
    for (int i = 0; i < 3 * FRAME_CYC; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    checks++;
    if (lows != 0 || frames_seen != f0) begin
      failures++;
      $display("FAIL stale_frame: got %0d low cycles %0d frames, required 0 and 0", lows, frames_seen - f0);
    end
    bus_read(A_STAT, d);
    checks++;
    if (d !== 32'h04) begin failures++; $display("FAIL post_reset_status: got %h, required 04", d); end
  endtask

  initial begin
    reset = 1'b1;
    MemRd = 1'b0;
    MemWr = 1'b0;
    addr  = '0;
    wdata = '0;
    #2;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_regs();
    test_single();
    test_back_to_back();
    test_overflow();
    test_irq();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
